// File: rtl/cocomem_dat_engine.sv
`default_nettype none
// ============================================================================
// Module   : cocomem_dat_engine
// Brief    : DAT MMU for the CoCo MEM Jr successor. It maps CPU address
//            bits 15:13 to a PHYS_BITS-wide bank through the external 16-bit
//            DAT SRAM. A sequential engine copies or identity-fills the eight
//            DAT entries of a task while it holds the CPU in halt.
// Revision : 1.0 - initial release
// ============================================================================
module cocomem_dat_engine #(
    parameter int TASK_BITS = 12,
    parameter int PHYS_BITS = 8
) (
    input  logic                   e,
    input  logic                   reset,
    input  logic [15:0]            address_cpu,
    input  logic                   r_w_cpu,
    input  logic [7:0]             data_cpu_in,
    output logic [7:0]             data_cpu_out,
    output logic                   data_cpu_oe,
    output logic [TASK_BITS+2:0]   address_dat,
    input  logic [15:0]            data_dat_in,
    output logic [15:0]            data_dat_out,
    output logic [1:0]             we_dat,
    output logic [PHYS_BITS-1:0]   bank_out,
    output logic                   mem_sel,
    output logic                   halt
);

    // DAT bits above PHYS_BITS always read and write as zero
    localparam logic [15:0] c_PHYS_MASK = 16'((32'd1 << PHYS_BITS) - 32'd1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_mmu_en;
    logic                 r_alt;
    logic [TASK_BITS-1:0] r_active_task;
    logic [TASK_BITS-1:0] r_access_task;
    logic                 r_busy;
    logic                 r_mode;
    logic [2:0]           r_slot;
    logic [15:0]          r_cap;

    // Register decode
    logic w_page_ff;
    logic w_sel_init0;
    logic w_sel_task_lo;
    logic w_sel_task_hi;
    logic w_sel_cmd;
    logic w_sel_win;
    logic w_cpu_wr;
    logic w_start;
    logic w_translate;

    assign w_page_ff     = (address_cpu[15:8] == 8'hFF);
    assign w_sel_init0   = (address_cpu == 16'hFF90);
    assign w_sel_task_lo = (address_cpu == 16'hFF91);
    assign w_sel_task_hi = (address_cpu == 16'hFF97);
    assign w_sel_cmd     = (address_cpu == 16'hFF98);
    assign w_sel_win     = (address_cpu[15:4] == 12'hFFA);

    // CPU writes are dropped entirely while the engine owns the DAT
    assign w_cpu_wr = !r_w_cpu && !r_busy;
    assign w_start  = (r_state == c_ST_IDLE) && w_cpu_wr && w_sel_cmd && data_cpu_in[7];

    // Tasks viewed at the architectural 12-bit width; missing bits read 0
    logic [11:0] w_active_ext;
    logic [11:0] w_access_ext;
    logic [11:0] w_target_ext;

    assign w_active_ext = 12'(r_active_task);
    assign w_access_ext = 12'(r_access_task);
    assign w_target_ext = r_alt ? w_access_ext : w_active_ext;

    // CPU-visible configuration registers
    always_ff @(posedge e or posedge reset) begin
        if (reset) begin
            r_mmu_en      <= 1'b0;
            r_alt         <= 1'b0;
            r_active_task <= '0;
            r_access_task <= '0;
        end else if (w_cpu_wr) begin
            if (w_sel_init0) begin
                r_mmu_en <= data_cpu_in[6];
            end
            if (w_sel_task_lo) begin
                r_alt <= data_cpu_in[7];
                if (data_cpu_in[7]) begin
                    r_access_task <= TASK_BITS'({w_access_ext[11:5], data_cpu_in[4:0]});
                end else begin
                    r_active_task <= TASK_BITS'({w_active_ext[11:5], data_cpu_in[4:0]});
                end
            end
            if (w_sel_task_hi) begin
                if (r_alt) begin
                    r_access_task <= TASK_BITS'({data_cpu_in[6:0], w_access_ext[4:0]});
                end else begin
                    r_active_task <= TASK_BITS'({data_cpu_in[6:0], w_active_ext[4:0]});
                end
            end
        end
    end

    // Engine state register
    always_ff @(posedge e or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Engine next state: copy alternates RD/WR, fill stays in WR
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = data_cpu_in[6] ? c_ST_WR : c_ST_RD;
                end
            end
            c_ST_RD: begin
                w_state_nxt = c_ST_WR;
            end
            c_ST_WR: begin
                if (r_slot == 3'd7) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = r_mode ? c_ST_WR : c_ST_RD;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Engine datapath: busy flag, mode, slot counter and read capture
    always_ff @(posedge e or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_mode <= 1'b0;
            r_slot <= 3'd0;
            r_cap  <= 16'h0000;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_busy <= 1'b1;
                        r_mode <= data_cpu_in[6];
                        r_slot <= 3'd0;
                    end
                end
                c_ST_RD: begin
                    r_cap <= data_dat_in & c_PHYS_MASK;
                end
                c_ST_WR: begin
                    if (r_slot == 3'd7) begin
                        r_busy <= 1'b0;
                        r_slot <= 3'd0;
                    end else begin
                        r_slot <= r_slot + 3'd1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // DAT SRAM address, write strobes and write data
    always_comb begin
        address_dat  = {r_active_task, address_cpu[15:13]};
        we_dat       = 2'b00;
        data_dat_out = {data_cpu_in, data_cpu_in} & c_PHYS_MASK;
        case (r_state)
            c_ST_RD: begin
                address_dat = {r_active_task, r_slot};
            end
            c_ST_WR: begin
                address_dat  = {r_access_task, r_slot};
                we_dat       = 2'b11;
                data_dat_out = r_mode ? 16'(r_slot) : r_cap;
            end
            default: begin
                if (w_sel_win) begin
                    address_dat = {r_access_task, address_cpu[3:1]};
                    if (!r_w_cpu) begin
                        we_dat = address_cpu[0] ? 2'b01 : 2'b10;
                    end
                end
            end
        endcase
    end

    // Translation is suspended for $FFxx and while the engine runs
    assign w_translate = r_mmu_en && !w_page_ff && !r_busy;
    assign bank_out    = w_translate ? data_dat_in[PHYS_BITS-1:0] : PHYS_BITS'(address_cpu[15:13]);
    assign mem_sel     = w_translate && (data_dat_in[PHYS_BITS-1:3] != '0);
    assign halt        = r_busy;

    logic [15:0] w_dat_rd;
    assign w_dat_rd = data_dat_in & c_PHYS_MASK;

    // CPU read-back multiplexer and bus drive enable
    always_comb begin
        data_cpu_out = 8'h00;
        data_cpu_oe  = 1'b0;
        if (w_sel_init0) begin
            data_cpu_out = {1'b0, r_mmu_en, 6'b000000};
            data_cpu_oe  = r_w_cpu;
        end else if (w_sel_task_lo) begin
            data_cpu_out = {r_alt, 2'b00, w_target_ext[4:0]};
            data_cpu_oe  = r_w_cpu;
        end else if (w_sel_task_hi) begin
            data_cpu_out = {1'b0, w_target_ext[11:5]};
            data_cpu_oe  = r_w_cpu;
        end else if (w_sel_cmd) begin
            data_cpu_out = {r_busy, r_mode, 6'b000000};
            data_cpu_oe  = r_w_cpu;
        end else if (w_sel_win) begin
            data_cpu_out = address_cpu[0] ? w_dat_rd[7:0] : w_dat_rd[15:8];
            data_cpu_oe  = r_w_cpu;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cocomem_dat_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cocomem_dat_engine
// Brief    : Directed bench for cocomem_dat_engine. Two builds (PHYS_BITS 8
//            and 16) share the CPU bus, each with its own DAT SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cocomem_dat_engine;

    logic        e;
    logic        reset;
    logic [15:0] address_cpu;
    logic        r_w_cpu;
    logic [7:0]  data_cpu_in;

    logic [7:0]  d8_out,   d16_out;
    logic        d8_oe,    d16_oe;
    logic [14:0] d8_adr,   d16_adr;
    logic [15:0] d8_din,   d16_din;
    logic [15:0] d8_dout,  d16_dout;
    logic [1:0]  d8_we,    d16_we;
    logic [7:0]  d8_bank;
    logic [15:0] d16_bank;
    logic        d8_msel,  d16_msel;
    logic        d8_halt,  d16_halt;

    logic [15:0] mem8  [0:32767];
    logic [15:0] mem16 [0:32767];

    int n_checks = 0;
    int n_errors = 0;

    cocomem_dat_engine #(.TASK_BITS(12), .PHYS_BITS(8)) dut8 (
        .e(e), .reset(reset), .address_cpu(address_cpu), .r_w_cpu(r_w_cpu),
        .data_cpu_in(data_cpu_in), .data_cpu_out(d8_out), .data_cpu_oe(d8_oe),
        .address_dat(d8_adr), .data_dat_in(d8_din), .data_dat_out(d8_dout),
        .we_dat(d8_we), .bank_out(d8_bank), .mem_sel(d8_msel), .halt(d8_halt)
    );

    cocomem_dat_engine #(.TASK_BITS(12), .PHYS_BITS(16)) dut16 (
        .e(e), .reset(reset), .address_cpu(address_cpu), .r_w_cpu(r_w_cpu),
        .data_cpu_in(data_cpu_in), .data_cpu_out(d16_out), .data_cpu_oe(d16_oe),
        .address_dat(d16_adr), .data_dat_in(d16_din), .data_dat_out(d16_dout),
        .we_dat(d16_we), .bank_out(d16_bank), .mem_sel(d16_msel), .halt(d16_halt)
    );

    // Asynchronous-read, edge-written DAT SRAM models
    assign d8_din  = mem8[d8_adr];
    assign d16_din = mem16[d16_adr];

    always @(posedge e) begin
        if (d8_we[1])  mem8[d8_adr][15:8]   <= d8_dout[15:8];
        if (d8_we[0])  mem8[d8_adr][7:0]    <= d8_dout[7:0];
        if (d16_we[1]) mem16[d16_adr][15:8] <= d16_dout[15:8];
        if (d16_we[0]) mem16[d16_adr][7:0]  <= d16_dout[7:0];
    end

    initial e = 1'b0;
    always #5 e = ~e;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        @(posedge e);
        #1;
        address_cpu = a;
        r_w_cpu     = rw;
        data_cpu_in = d;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        drive(a, 1'b0, d);
        drive(16'h0000, 1'b1, 8'h00);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] r8, output logic [7:0] r16);
        drive(a, 1'b1, 8'h00);
        @(negedge e);
        r8  = d8_out;
        r16 = d16_out;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (d8_halt && k < 40) begin
            @(negedge e);
            k++;
        end
        check("engine_timeout", {31'd0, d8_halt}, 32'd0);
    endtask

    logic [7:0] r8, r16;
    int         cnt8, cnt16;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem8[i]  = 16'h0000;
            mem16[i] = 16'h0000;
        end
        reset       = 1'b1;
        address_cpu = 16'hE000;
        r_w_cpu     = 1'b1;
        data_cpu_in = 8'h00;

        // 1: reset state
        repeat (3) @(posedge e);
        @(negedge e);
        reset = 1'b0;
        @(negedge e);
        check("rst_bank",  d8_bank, 32'h7);
        check("rst_bank16", d16_bank, 32'h7);
        check("rst_msel",  d8_msel, 32'h0);
        check("rst_halt",  d8_halt, 32'h0);
        check("rst_oe",    d8_oe,   32'h0);
        check("rst_we",    d8_we,   32'h0);

        // 2: DAT window byte writes, masking and translation
        cpu_write(16'hFF91, 8'h85);
        cpu_write(16'hFF97, 8'h00);
        drive(16'hFFA2, 1'b0, 8'h01);
        @(negedge e);
        check("win_we_hi",   d8_we,    32'h2);
        check("win_we_hi16", d16_we,   32'h2);
        check("win_adr",     d8_adr,   32'h29);
        check("win_dout8",   d8_dout,  32'h0001);
        check("win_dout16",  d16_dout, 32'h0101);
        drive(16'hFFA3, 1'b0, 8'h23);
        @(negedge e);
        check("win_we_lo",   d8_we,    32'h1);
        check("win_adr_lo",  d8_adr,   32'h29);
        drive(16'h0000, 1'b1, 8'h00);
        cpu_read(16'hFFA2, r8, r16);
        check("rd_hi16", r16, 32'h01);
        check("rd_hi8",  r8,  32'h00);
        check("rd_oe",   d8_oe, 32'h1);
        cpu_read(16'hFFA3, r8, r16);
        check("rd_lo16", r16, 32'h23);
        check("rd_lo8",  r8,  32'h23);
        cpu_write(16'hFF91, 8'h05);
        cpu_write(16'hFF97, 8'h00);
        cpu_write(16'hFF90, 8'h40);
        cpu_read(16'hFF90, r8, r16);
        check("rd_init0", r8, 32'h40);
        cpu_read(16'hFF91, r8, r16);
        check("rd_task_lo", r8, 32'h05);
        drive(16'h2000, 1'b1, 8'h00);
        @(negedge e);
        check("xlat_bank8",  d8_bank,  32'h23);
        check("xlat_msel8",  d8_msel,  32'h1);
        check("xlat_bank16", d16_bank, 32'h0123);
        check("xlat_msel16", d16_msel, 32'h1);
        check("xlat_oe",     d8_oe,    32'h0);
        drive(16'hFFF0, 1'b1, 8'h00);
        @(negedge e);
        check("io_bank", d8_bank, 32'h7);
        check("io_msel", d8_msel, 32'h0);

        // 3: identity fill of task 3
        cpu_write(16'hFF91, 8'h83);
        cpu_write(16'hFF98, 8'hC0);
        cnt8  = 0;
        cnt16 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge e);
            if (d8_halt)  cnt8++;
            if (d16_halt) cnt16++;
        end
        check("fill_halt8",  cnt8,  32'd8);
        check("fill_halt16", cnt16, 32'd8);
        cpu_read(16'hFF98, r8, r16);
        check("fill_cmd_rd", r8, 32'h40);
        cpu_write(16'hFF91, 8'h03);
        for (int s = 0; s < 8; s++) begin
            drive({3'(s), 13'h0000}, 1'b1, 8'h00);
            @(negedge e);
            check("fill_bank", d8_bank, 32'(s));
            check("fill_msel", d8_msel, 32'h0);
            cpu_read(16'hFFA1 + 16'(2 * s), r8, r16);
            check("fill_win_lo", r8, 32'(s));
            cpu_read(16'hFFA0 + 16'(2 * s), r8, r16);
            check("fill_win_hi16", r16, 32'h00);
        end

        // 4: copy task 1 -> task 9
        cpu_write(16'hFF91, 8'h81);
        for (int s = 0; s < 8; s++) begin
            cpu_write(16'hFFA1 + 16'(2 * s), 8'h40 + 8'(s));
        end
        cpu_write(16'hFF91, 8'h01);
        cpu_write(16'hFF91, 8'h89);
        cpu_write(16'hFF98, 8'h80);
        for (int k = 1; k <= 16; k++) begin
            @(negedge e);
            check("copy_halt", d8_halt, 32'h1);
            if (k % 2 == 1) begin
                check("copy_rd_adr", d8_adr, {17'd0, 12'd1, 3'((k - 1) / 2)});
                check("copy_rd_we",  d8_we,  32'h0);
            end else begin
                check("copy_wr_adr",  d8_adr,  {17'd0, 12'd9, 3'((k - 2) / 2)});
                check("copy_wr_we",   d8_we,   32'h3);
                check("copy_wr_data", d8_dout, 32'h40 + 32'((k - 2) / 2));
            end
        end
        @(negedge e);
        check("copy_done_halt", d8_halt, 32'h0);
        cpu_write(16'hFF91, 8'h09);
        drive(16'h2000, 1'b1, 8'h00);
        @(negedge e);
        check("copy_bank",   d8_bank,  32'h41);
        check("copy_msel",   d8_msel,  32'h1);
        check("copy_bank16", d16_bank, 32'h41);
        drive(16'hE000, 1'b1, 8'h00);
        @(negedge e);
        check("copy_bank7", d8_bank, 32'h47);

        // 5: writes ignored during a copy (task 9 onto itself)
        cpu_write(16'hFF91, 8'h89);
        cpu_write(16'hFF98, 8'h80);
        drive(16'hFF98, 1'b0, 8'hC0);
        @(negedge e);
        check("busy_we_wr0", d8_we, 32'h3);
        drive(16'hFFA0, 1'b0, 8'hFF);
        @(negedge e);
        check("busy_we_rd1",  d8_we,  32'h0);
        check("busy_adr_rd1", d8_adr, {17'd0, 12'd9, 3'd1});
        drive(16'hFF91, 1'b0, 8'h85);
        @(negedge e);
        check("busy_we_wr1",   d8_we,   32'h3);
        check("busy_data_wr1", d8_dout, 32'h41);
        drive(16'hFF98, 1'b1, 8'h00);
        @(negedge e);
        check("busy_cmd_rd", d8_out, 32'h80);
        check("busy_cmd_oe", d8_oe,  32'h1);
        check("busy_bank",   d8_bank, 32'h7);
        drive(16'h0000, 1'b1, 8'h00);
        wait_idle();
        cpu_read(16'hFF91, r8, r16);
        check("busy_task_kept", r8, 32'h89);
        cpu_read(16'hFF98, r8, r16);
        check("busy_mode_kept", r8, 32'h00);
        cpu_read(16'hFFA0, r8, r16);
        check("busy_win_kept16", r16, 32'h00);
        for (int s = 0; s < 8; s++) begin
            drive({3'(s), 13'h0000}, 1'b1, 8'h00);
            @(negedge e);
            check("self_copy_bank", d8_bank, 32'h40 + 32'(s));
        end

        // 6: reset in the middle of a copy 1 -> 12
        cpu_write(16'hFF91, 8'h8C);
        for (int s = 0; s < 8; s++) begin
            cpu_write(16'hFFA1 + 16'(2 * s), 8'hA0 + 8'(s));
        end
        cpu_write(16'hFF91, 8'h01);
        cpu_write(16'hFF91, 8'h8C);
        cpu_write(16'hFF98, 8'h80);
        repeat (4) @(posedge e);
        #2;
        reset = 1'b1;
        #1;
        check("abort_halt8",  d8_halt,  32'h0);
        check("abort_halt16", d16_halt, 32'h0);
        check("abort_we",     d8_we,    32'h0);
        check("abort_adr",    d8_adr,   32'h0);
        @(negedge e);
        reset = 1'b0;
        cpu_read(16'hFF90, r8, r16);
        check("abort_init0", r8, 32'h00);
        cpu_read(16'hFF98, r8, r16);
        check("abort_cmd", r8, 32'h00);
        cpu_write(16'hFF91, 8'h8C);
        for (int s = 0; s < 8; s++) begin
            cpu_read(16'hFFA1 + 16'(2 * s), r8, r16);
            check("abort_entry", r8, (s < 2) ? (32'h40 + 32'(s)) : (32'hA0 + 32'(s)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
